// File: rtl/ping_controller_pkg.sv
// ping_controller_pkg: shared FSM state type and default measurement timing
package ping_controller_pkg;
  typedef enum logic [2:0] {IDLE, BURST, BLANK, LISTEN, REARM} ping_state_t;
  localparam int BURST_HALF_DEF   = 625;
  localparam int BURST_PULSES_DEF = 8;
  localparam int BLANK_CYC_DEF    = 50000;
  localparam int WINDOW_CYC_DEF   = 1200000;
  localparam int REARM_CYC_DEF    = 100000;
  localparam int TOF_W_DEF        = 24;
endpackage

// File: rtl/ping_controller_tone_gen.sv
// tone_gen: complementary transmit tone of a fixed number of periods, flags its last cycle
module tone_gen #(
  parameter int HALF   = 625,
  parameter int PULSES = 8
) (
  input  logic gclk,
  input  logic rst,
  input  logic go,
  output logic tx_p,
  output logic tx_n,
  output logic tone_done
);
  localparam int HW = $clog2(HALF + 1);
  localparam int PW = $clog2(2 * PULSES + 1);
  logic [HW-1:0] hc;
  logic [PW-1:0] pc;
  logic active;
  assign tone_done = active && hc == '0 && pc == '0;
  // half-period down-counter nested in a half-count down-counter; drive swaps on each half wrap
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      hc <= '0;
      pc <= '0;
      tx_p <= 1'b0;
      tx_n <= 1'b0;
    end else if (go) begin
      active <= 1'b1;
      hc <= HW'(HALF - 1);
      pc <= PW'(2 * PULSES - 1);
      tx_p <= 1'b1;
      tx_n <= 1'b0;
    end else if (active) begin
      if (hc != '0) begin
        hc <= hc - 1'b1;
      end else if (pc == '0) begin
        active <= 1'b0;
        tx_p <= 1'b0;
        tx_n <= 1'b0;
      end else begin
        hc <= HW'(HALF - 1);
        pc <= pc - 1'b1;
        tx_p <= ~tx_p;
        tx_n <= ~tx_n;
      end
    end
  end
endmodule

// File: rtl/ping_controller.sv
// ping_controller: sequences burst, blanking, listening window and time-of-flight capture
module ping_controller
  import ping_controller_pkg::*;
#(
  parameter int BURST_HALF   = BURST_HALF_DEF,
  parameter int BURST_PULSES = BURST_PULSES_DEF,
  parameter int BLANK_CYC    = BLANK_CYC_DEF,
  parameter int WINDOW_CYC   = WINDOW_CYC_DEF,
  parameter int REARM_CYC    = REARM_CYC_DEF,
  parameter int TOF_W        = TOF_W_DEF
) (
  input  logic             gclk,
  input  logic             rst,
  input  logic             start,
  input  logic             detected,
  output logic             tx_p,
  output logic             tx_n,
  output logic             detect_en,
  output logic             busy,
  output logic [TOF_W-1:0] tof,
  output logic             tof_valid,
  output logic             timeout
);
  localparam int PH_MAX = BLANK_CYC > WINDOW_CYC ? (BLANK_CYC > REARM_CYC ? BLANK_CYC : REARM_CYC)
                                                 : (WINDOW_CYC > REARM_CYC ? WINDOW_CYC : REARM_CYC);
  localparam int PW = $clog2(PH_MAX + 1);
  ping_state_t state, nxt;
  logic [PW-1:0] ph, ph_nxt;
  logic [TOF_W-1:0] cnt, cnt_nxt;
  logic go, hit, expire, tone_done;
  assign go = state == IDLE && start;
  tone_gen #(.HALF(BURST_HALF), .PULSES(BURST_PULSES)) u_tone (
    .gclk      (gclk),
    .rst       (rst),
    .go        (go),
    .tx_p      (tx_p),
    .tx_n      (tx_n),
    .tone_done (tone_done)
  );
  // next state, phase counter reload on every timed transition, and saturating ToF count
  always_comb begin
    nxt = state;
    ph_nxt = ph;
    hit = 1'b0;
    expire = 1'b0;
    case (state)
      IDLE:   nxt = start ? BURST : IDLE;
      BURST: begin
        nxt = tone_done ? BLANK : BURST;
        ph_nxt = PW'(BLANK_CYC - 1);
      end
      BLANK: begin
        nxt = ph == '0 ? LISTEN : BLANK;
        ph_nxt = ph == '0 ? PW'(WINDOW_CYC - 1) : ph - 1'b1;
      end
      LISTEN: begin
        hit = detected;
        expire = !detected && ph == '0;
        nxt = hit || expire ? REARM : LISTEN;
        ph_nxt = hit || expire ? PW'(REARM_CYC - 1) : ph - 1'b1;
      end
      REARM: begin
        nxt = ph == '0 ? IDLE : REARM;
        ph_nxt = ph - 1'b1;
      end
      default: nxt = IDLE;
    endcase
    cnt_nxt = go ? '0 : (state inside {BURST, BLANK, LISTEN}) && cnt != '1 ? cnt + 1'b1 : cnt;
  end
  // state register with outputs registered from the next state
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ph <= '0;
      cnt <= '0;
      tof <= '0;
      tof_valid <= 1'b0;
      timeout <= 1'b0;
      detect_en <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= nxt;
      ph <= ph_nxt;
      cnt <= cnt_nxt;
      tof <= hit ? cnt : tof;
      tof_valid <= hit;
      timeout <= expire;
      detect_en <= nxt == LISTEN;
      busy <= nxt != IDLE;
    end
  end
endmodule

// File: tb/tb_ping_controller.sv
// tb_ping_controller: scoreboard bench for ping_controller, full-width and saturating instances
module tb_ping_controller;
  logic gclk = 1'b0;
  logic rst, start, detected, hold;
  logic tx_p, tx_n, detect_en, busy, tof_valid, timeout;
  logic s_tx_p, s_tx_n, s_detect_en, s_busy, s_tof_valid, s_timeout;
  logic [7:0] tof;
  logic [3:0] s_tof;
  int n_tests = 0;
  int n_fail = 0;
  typedef struct packed {
    logic       hit;
    logic [7:0] tof;
    logic [3:0] tof_s;
  } exp_t;
  exp_t sb[$];
  exp_t m_e;
  logic [7:0] last_tof = '0;
  logic [3:0] last_tof_s = '0;

  always #5 gclk = ~gclk;

  ping_controller #(.BURST_HALF(4), .BURST_PULSES(2), .BLANK_CYC(5), .WINDOW_CYC(20), .REARM_CYC(3), .TOF_W(8)) dut (
    .gclk(gclk), .rst(rst), .start(start), .detected(detected), .tx_p(tx_p), .tx_n(tx_n),
    .detect_en(detect_en), .busy(busy), .tof(tof), .tof_valid(tof_valid), .timeout(timeout)
  );

  ping_controller #(.BURST_HALF(4), .BURST_PULSES(2), .BLANK_CYC(5), .WINDOW_CYC(20), .REARM_CYC(3), .TOF_W(4)) sat (
    .gclk(gclk), .rst(rst), .start(start), .detected(detected), .tx_p(s_tx_p), .tx_n(s_tx_n),
    .detect_en(s_detect_en), .busy(s_busy), .tof(s_tof), .tof_valid(s_tof_valid), .timeout(s_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // result monitor: every strobe from either instance must match the oldest expected result
  always @(negedge gclk) begin
    if (!rst && (tof_valid || timeout || s_tof_valid || s_timeout)) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        m_e = sb.pop_front();
        check("res_kind", {tof_valid, timeout}, m_e.hit ? 2'b10 : 2'b01);
        check("res_kind_sat", {s_tof_valid, s_timeout}, m_e.hit ? 2'b10 : 2'b01);
        check("res_tof", tof, m_e.tof);
        check("res_tof_sat", s_tof, m_e.tof_s);
      end
    end
  end

  // one measurement with detected pulsed at counter d (negative or outside the window: none)
  task automatic measure(input int d);
    int e;
    bit h;
    exp_t x;
    logic [5:0] ex;
    h = d >= 21 && d <= 40;
    e = h ? d + 1 : 41;
    x.hit = h;
    x.tof = h ? 8'(d) : last_tof;
    x.tof_s = h ? (d > 15 ? 4'hF : 4'(d)) : last_tof_s;
    if (h) begin
      last_tof = x.tof;
      last_tof_s = x.tof_s;
    end
    sb.push_back(x);
    start = 1'b1;
    for (int i = 0; i <= e + 3; i++) begin
      @(negedge gclk);
      if (!hold) start = 1'b0;
      ex = {i < 16 && (i / 4) % 2 == 0, i < 16 && (i / 4) % 2 == 1, i >= 21 && i < e, i < e + 3, h && i == e, !h && i == e};
      check($sformatf("cyc%0d_d%0d", i, d), {tx_p, tx_n, detect_en, busy, tof_valid, timeout}, {26'd0, ex});
      detected = i == d;
    end
    detected = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    detected = 1'b0;
    hold = 1'b0;
    repeat (2) @(negedge gclk);
    check("reset_state", {tx_p, tx_n, detect_en, busy, tof_valid, timeout, tof}, 0);
    check("reset_state_sat", {s_tx_p, s_tx_n, s_detect_en, s_busy, s_tof_valid, s_timeout, s_tof}, 0);
    rst = 1'b0;
    @(negedge gclk);
    check("idle_state", {tx_p, tx_n, detect_en, busy, tof_valid, timeout}, 0);
    measure(30);
    measure(-1);
    measure(18);
    measure(40);
    measure(21);
    measure(25);
    hold = 1'b1;
    measure(33);
    measure(22);
    hold = 1'b0;
    start = 1'b0;
    start = 1'b1;
    @(negedge gclk);
    start = 1'b0;
    repeat (2) @(negedge gclk);
    check("pre_rst_drive", {tx_p, tx_n, busy}, 3'b101);
    #2 rst = 1'b1;
    #1 check("rst_async", {tx_p, tx_n, busy, s_tx_p, s_tx_n, s_busy}, 0);
    @(negedge gclk);
    rst = 1'b0;
    last_tof = '0;
    last_tof_s = '0;
    check("post_rst_tof", tof, 0);
    measure(30);
    measure(-1);
    @(negedge gclk);
    check("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
